// File: rtl/mdp3_msg_parser.sv
// MDP3 byte-stream message collector with length check and field extraction.
// Optional MDP3_MSG_COUNTERS_EN adds saturating good/error frame counters.
module mdp3_msg_parser #(
  parameter int MSG_BYTES   = 37,
  parameter int ENTRIES_IDX = 11,
  parameter int ACTION_IDX  = 12,
  parameter int TYPE_IDX    = 13,
  parameter int ORDERS_IDX  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*MSG_BYTES-1:0] out_msg,
  output logic [7:0]             out_num_md_entries,
  output logic [7:0]             out_md_update_action,
  output logic [7:0]             out_md_entry_type,
  output logic [7:0]             out_num_orders,
  output logic [15:0]            msg_count,
  output logic [15:0]            err_count
);

  localparam int W = 8 * MSG_BYTES;
  localparam logic [5:0] LAST = 6'(MSG_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DISCARD,
    S_HOLD
  } state_t;

  state_t         state_q, state_d;
  logic [5:0]     idx_q, idx_d;
  logic [W-1:0]   buf_q, buf_d;
  logic [W-1:0]   msg_q, msg_d;
  logic [W-1:0]   buf_wr;
  logic [5:0]     wpos;
  logic           acc;
  logic           msg_ev;
  logic           err_ev;

  assign in_ready  = (state_q != S_HOLD);
  assign out_valid = (state_q == S_HOLD);
  assign acc       = in_valid && in_ready;
  assign wpos      = in_sop ? 6'd0 : idx_q;

  // Current byte merged into the collect buffer at its frame position
  always_comb begin
    buf_wr = buf_q;
    for (int i = 0; i < MSG_BYTES; i++) begin
      if (wpos == i[5:0]) buf_wr[W-8-8*i +: 8] = in_data;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    msg_d   = msg_q;
    msg_ev  = 1'b0;
    err_ev  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (acc && in_sop) begin
          if (in_eop) begin
            err_ev = 1'b1;
          end else begin
            buf_d   = buf_wr;
            idx_d   = 6'd1;
            state_d = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (acc) begin
          if (in_sop) begin
            err_ev = 1'b1;
            if (in_eop) begin
              idx_d   = 6'd0;
              state_d = S_IDLE;
            end else begin
              buf_d = buf_wr;
              idx_d = 6'd1;
            end
          end else if (in_eop) begin
            idx_d = 6'd0;
            if (idx_q == LAST) begin
              msg_d   = buf_wr;
              msg_ev  = 1'b1;
              state_d = S_HOLD;
            end else begin
              err_ev  = 1'b1;
              state_d = S_IDLE;
            end
          end else if (idx_q == LAST) begin
            err_ev  = 1'b1;
            idx_d   = 6'd0;
            state_d = S_DISCARD;
          end else begin
            buf_d = buf_wr;
            idx_d = idx_q + 6'd1;
          end
        end
      end
      S_DISCARD: begin
        if (acc) begin
          if (in_eop) begin
            state_d = S_IDLE;
          end else if (in_sop) begin
            buf_d   = buf_wr;
            idx_d   = 6'd1;
            state_d = S_COLLECT;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
      msg_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      msg_q   <= msg_d;
    end
  end

  assign out_msg              = msg_q;
  assign out_num_md_entries   = msg_q[W-8-8*ENTRIES_IDX +: 8];
  assign out_md_update_action = msg_q[W-8-8*ACTION_IDX +: 8];
  assign out_md_entry_type    = msg_q[W-8-8*TYPE_IDX +: 8];
  assign out_num_orders       = msg_q[W-8-8*ORDERS_IDX +: 8];

`ifdef MDP3_MSG_COUNTERS_EN
  logic [15:0] msg_cnt_q, msg_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    msg_cnt_d = msg_cnt_q;
    err_cnt_d = err_cnt_q;
    if (msg_ev && msg_cnt_q != 16'hFFFF) msg_cnt_d = msg_cnt_q + 16'd1;
    if (err_ev && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      msg_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      msg_cnt_q <= msg_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign msg_count = msg_cnt_q;
  assign err_count = err_cnt_q;
`else
  logic unused_ev;
  assign unused_ev = msg_ev ^ err_ev;
  assign msg_count = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_mdp3_msg_parser.sv
// Directed scoreboard bench for mdp3_msg_parser.
// Counter expectations follow MDP3_MSG_COUNTERS_EN.
module tb_mdp3_msg_parser;

  localparam int NB = 37;
  localparam int W  = 8 * NB;
`ifdef MDP3_MSG_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_sop = 1'b0;
  logic         in_eop = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_msg;
  logic [7:0]   f_ent, f_act, f_typ, f_ord;
  logic [15:0]  msg_count, err_count;

  mdp3_msg_parser dut (
    .clk                 (clk),
    .reset               (reset),
    .in_valid            (in_valid),
    .in_sop              (in_sop),
    .in_eop              (in_eop),
    .in_data             (in_data),
    .in_ready            (in_ready),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_msg             (out_msg),
    .out_num_md_entries  (f_ent),
    .out_md_update_action(f_act),
    .out_md_entry_type   (f_typ),
    .out_num_orders      (f_ord),
    .msg_count           (msg_count),
    .err_count           (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] msg;
    logic [15:0]  mc;
  } exp_t;

  exp_t         sb[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           exp_mc = 0;
  int           exp_ec = 0;
  logic [W-1:0] good_v;
  time          t_rel, t_acc;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gbyte(input int i);
    return good_v[W-1-8*i -: 8];
  endfunction

  function automatic logic [15:0] cexp(input int n);
    return CNT_EN ? 16'(n) : 16'd0;
  endfunction

  task automatic push_good();
    exp_t it;
    exp_mc++;
    it.msg = good_v;
    it.mc  = cexp(exp_mc);
    sb.push_back(it);
  endtask

  task automatic send(input logic [7:0] d, input logic s, input logic e);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("send_timeout", W'(n), '0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  // Bytes past the good frame are filler; eop_at < 0 means no eop
  task automatic send_frame(input int n, input int eop_at, input bit push);
    for (int i = 0; i < n; i++) begin
      if (push && i == eop_at) push_good();
      send(i < NB ? gbyte(i) : 8'hEE, i == 0, i == eop_at);
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_msg_count"}, W'(msg_count), W'(cexp(exp_mc)));
    chk({tag, "_err_count"}, W'(err_count), W'(cexp(exp_ec)));
  endtask

  // Output side: every handshake must match the oldest expected message
  always @(negedge clk) begin
    exp_t it;
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", W'(out_valid), '0);
      end else begin
        it = sb.pop_front();
        chk("out_msg", out_msg, it.msg);
        chk("entries", W'(f_ent), W'(it.msg[W-1-8*11 -: 8]));
        chk("action", W'(f_act), W'(it.msg[W-1-8*12 -: 8]));
        chk("type", W'(f_typ), W'(it.msg[W-1-8*13 -: 8]));
        chk("orders", W'(f_ord), W'(it.msg[W-1-8*32 -: 8]));
        chk("hold_msg_count", W'(msg_count), W'(it.mc));
      end
    end
  end

  initial begin
    int n;
    good_v = 296'hC0C21C023D0100006803800100007B0000000C000000A0475F3B000000000F0002C9000000;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_out_msg", out_msg, '0);
    chk("rst_entries", W'(f_ent), '0);
    chk("rst_orders", W'(f_ord), '0);
    chk_cnt("rst");

    // Good frame
    send_frame(NB, NB - 1, 1'b1);
    chk("lat_out_valid", W'(out_valid), W'(1));
    chk("lat_in_ready", W'(in_ready), '0);
    chk("good_msg", out_msg, good_v);
    chk("good_entries", W'(f_ent), W'(8'h01));
    chk("good_action", W'(f_act), W'(8'h00));
    chk("good_type", W'(f_typ), W'(8'h00));
    chk("good_orders", W'(f_ord), W'(8'h02));
    @(posedge clk);
    #1;
    chk("good_release", W'(out_valid), '0);
    chk_cnt("good");

    // Backpressure with a new sop offered during hold
    out_ready = 1'b0;
    send_frame(NB, NB - 1, 1'b1);
    fork
      begin
        send(gbyte(0), 1'b1, 1'b0);
        t_acc = $time;
      end
      begin
        repeat (10) begin
          @(negedge clk);
          chk("bp_valid", W'(out_valid), W'(1));
          chk("bp_in_ready", W'(in_ready), '0);
          chk("bp_msg", out_msg, good_v);
        end
        @(posedge clk);
        #2;
        t_rel = $time;
        out_ready = 1'b1;
      end
    join
    chk("bp_order", W'(t_acc > t_rel), W'(1));
    for (int i = 1; i < NB; i++) begin
      if (i == NB - 1) push_good();
      send(gbyte(i), 1'b0, i == NB - 1);
    end
    @(posedge clk);
    #1;
    chk_cnt("bp");

    // Short frame
    send_frame(21, 20, 1'b0);
    exp_ec++;
    chk("short_in_ready", W'(in_ready), W'(1));
    chk("short_valid", W'(out_valid), '0);
    chk_cnt("short");

    // Single-byte sop+eop in idle
    send(8'h55, 1'b1, 1'b1);
    exp_ec++;
    chk("one_valid", W'(out_valid), '0);
    chk_cnt("one");

    // Long frame followed by a good frame
    send_frame(40, 39, 1'b0);
    exp_ec++;
    chk_cnt("long");
    send_frame(NB, NB - 1, 1'b1);
    @(posedge clk);
    #1;
    chk_cnt("after_long");

    // Restart: sop at byte 15 begins a good frame
    send_frame(15, -1, 1'b0);
    send_frame(NB, NB - 1, 1'b1);
    exp_ec++;
    chk("restart_entries", W'(f_ent), W'(8'h01));
    @(posedge clk);
    #1;
    chk_cnt("restart");

    // Reset mid-frame, then a good frame
    send_frame(31, -1, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_mc = 0;
    exp_ec = 0;
    chk("mid_rst_valid", W'(out_valid), '0);
    chk("mid_rst_ready", W'(in_ready), W'(1));
    chk("mid_rst_msg", out_msg, '0);
    chk_cnt("mid_rst");
    send_frame(NB, NB - 1, 1'b1);
    @(posedge clk);
    #1;
    chk_cnt("final");

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      n++;
      @(posedge clk);
    end
    chk("sb_drain", W'(sb.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
